// File: rtl/i2c_bit_driver.sv
// i2c_bit_driver
//   Bit-level I2C drive stage. Executes one bus primitive per accepted
//   command (START, STOP, WRITE bit, READ bit) as four quarter-bit phases
//   A..D, driving open-drain enables for SCL/SDA. Uses the already
//   synchronized/debounced bus levels for clock stretching, read data and
//   arbitration-loss detection.
//
// Parameters
//   QUARTER  fastClock cycles per quarter bit period (2..65535)
//   CW       phase-counter width, at least clog2(QUARTER)
//
// Ports
//   fastClock  in   sole clock, rising edge
//   reset      in   asynchronous, active-high
//   cmdValid   in   command request
//   cmdReady   out  command can be accepted (~busy)
//   cmd        in   00 START, 01 STOP, 10 WRITE, 11 READ
//   txBit      in   data bit for WRITE
//   sclIn      in   synchronized SCL level
//   sdaIn      in   synchronized SDA level
//   sclOe      out  1 = pull SCL low
//   sdaOe      out  1 = pull SDA low
//   busy       out  command in progress
//   done       out  one-cycle completion pulse
//   rxBit      out  SDA level sampled in the current/last READ or WRITE
//   arbLost    out  one-cycle pulse with done when arbitration was lost
module i2c_bit_driver #(
  parameter int QUARTER = 125,
  parameter int CW      = 16
) (
  input  logic       fastClock,
  input  logic       reset,
  input  logic       cmdValid,
  output logic       cmdReady,
  input  logic [1:0] cmd,
  input  logic       txBit,
  input  logic       sclIn,
  input  logic       sdaIn,
  output logic       sclOe,
  output logic       sdaOe,
  output logic       busy,
  output logic       done,
  output logic       rxBit,
  output logic       arbLost
);

  typedef enum logic [2:0] {
    IDLE,
    PHASE_A,
    PHASE_B,
    PHASE_C,
    PHASE_D
  } phaseT;

  typedef enum logic [1:0] {
    CMD_START = 2'b00,
    CMD_STOP  = 2'b01,
    CMD_WRITE = 2'b10,
    CMD_READ  = 2'b11
  } cmdT;

  localparam logic [CW-1:0] LAST = CW'(QUARTER - 1);

  phaseT         state, stateN;
  logic [CW-1:0] cnt, cntN;
  cmdT           cmdQ, cmdN;
  logic          txQ, txN;
  logic          sclN, sdaN;
  logic          doneN, arbN, rxN;
  logic          flag, flagN;

  // {sclOe, sdaOe} for a given command, inverted data bit and phase.
  function automatic logic [1:0] drivePair(input cmdT c, input logic d,
                                           input phaseT p);
    logic [1:0] r;
    r = '0;
    unique case (c)
      CMD_START: r = (p == PHASE_D) ? 2'b11 : (p == PHASE_C) ? 2'b01 : 2'b00;
      CMD_STOP:  r = (p == PHASE_A) ? 2'b11 : (p == PHASE_D) ? 2'b00 : 2'b01;
      CMD_WRITE: r = {(p == PHASE_A) || (p == PHASE_D), d};
      CMD_READ:  r = {(p == PHASE_A) || (p == PHASE_D), 1'b0};
    endcase
    return r;
  endfunction

  assign busy     = (state != IDLE);
  assign cmdReady = ~busy;

  always_comb begin
    stateN = state;
    cntN   = cnt;
    cmdN   = cmdQ;
    txN    = txQ;
    sclN   = sclOe;
    sdaN   = sdaOe;
    doneN  = 1'b0;
    arbN   = 1'b0;
    rxN    = rxBit;
    flagN  = flag;
    unique case (state)
      IDLE: begin
        if (cmdValid && cmdReady) begin
          cmdN         = cmdT'(cmd);
          txN          = txBit;
          flagN        = 1'b0;
          stateN       = PHASE_A;
          cntN         = '0;
          {sclN, sdaN} = drivePair(cmdT'(cmd), ~txBit, PHASE_A);
        end
      end
      PHASE_A: begin
        if (cnt == LAST) begin
          stateN       = PHASE_B;
          cntN         = '0;
          {sclN, sdaN} = drivePair(cmdQ, ~txQ, PHASE_B);
        end else begin
          cntN = cnt + CW'(1);
        end
      end
      PHASE_B: begin
        // A slave holding SCL low freezes the count, so the high time of
        // SCL is always a full quarter regardless of stretch length.
        if (sclIn) begin
          if (cnt == LAST) begin
            if (cmdQ == CMD_READ || cmdQ == CMD_WRITE) begin
              rxN = sdaIn;
            end
            if (cmdQ == CMD_WRITE && txQ && !sdaIn) begin
              flagN = 1'b1;
            end
            stateN       = PHASE_C;
            cntN         = '0;
            {sclN, sdaN} = drivePair(cmdQ, ~txQ, PHASE_C);
          end else begin
            cntN = cnt + CW'(1);
          end
        end
      end
      PHASE_C: begin
        if (cnt == LAST) begin
          stateN       = PHASE_D;
          cntN         = '0;
          {sclN, sdaN} = drivePair(cmdQ, ~txQ, PHASE_D);
        end else begin
          cntN = cnt + CW'(1);
        end
      end
      PHASE_D: begin
        // Bus enables keep their phase D values while idle.
        if (cnt == LAST) begin
          stateN = IDLE;
          cntN   = '0;
          doneN  = 1'b1;
          arbN   = flag;
        end else begin
          cntN = cnt + CW'(1);
        end
      end
      default: stateN = IDLE;
    endcase
  end

  always_ff @(posedge fastClock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      cmdQ    <= CMD_START;
      txQ     <= 1'b0;
      sclOe   <= 1'b0;
      sdaOe   <= 1'b0;
      done    <= 1'b0;
      rxBit   <= 1'b0;
      arbLost <= 1'b0;
      flag    <= 1'b0;
    end else begin
      state   <= stateN;
      cnt     <= cntN;
      cmdQ    <= cmdN;
      txQ     <= txN;
      sclOe   <= sclN;
      sdaOe   <= sdaN;
      done    <= doneN;
      rxBit   <= rxN;
      arbLost <= arbN;
      flag    <= flagN;
    end
  end

endmodule

// File: tb/tb_i2c_bit_driver.sv
// tb_i2c_bit_driver
//   Directed bench for i2c_bit_driver with QUARTER=4. Bus lines follow the
//   inverted output enables unless overridden to model a slave driving low.
module tb_i2c_bit_driver;

  localparam int Q = 4;

  logic       fastClock = 1'b0;
  logic       reset;
  logic       cmdValid;
  logic       cmdReady;
  logic [1:0] cmd;
  logic       txBit;
  logic       sclIn;
  logic       sdaIn;
  logic       sclOe;
  logic       sdaOe;
  logic       busy;
  logic       done;
  logic       rxBit;
  logic       arbLost;

  logic sclOvr, sclVal, sdaOvr, sdaVal;
  int   checks   = 0;
  int   failures = 0;

  assign sclIn = sclOvr ? sclVal : ~sclOe;
  assign sdaIn = sdaOvr ? sdaVal : ~sdaOe;

  always #5 fastClock = ~fastClock;

  i2c_bit_driver #(
    .QUARTER(Q),
    .CW     (16)
  ) dut (
    .fastClock(fastClock),
    .reset    (reset),
    .cmdValid (cmdValid),
    .cmdReady (cmdReady),
    .cmd      (cmd),
    .txBit    (txBit),
    .sclIn    (sclIn),
    .sdaIn    (sdaIn),
    .sclOe    (sclOe),
    .sdaOe    (sdaOe),
    .busy     (busy),
    .done     (done),
    .rxBit    (rxBit),
    .arbLost  (arbLost)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Request a command for one edge; returns in the first busy cycle.
  task automatic issue(input logic [1:0] c, input logic tx);
    cmdValid = 1'b1;
    cmd      = c;
    txBit    = tx;
    @(negedge fastClock);
    cmdValid = 1'b0;
  endtask

  // pairs = {A,B,C,D} expected {sclOe,sdaOe}; checks cycles first..first+count-1.
  task automatic watch(input string tag, input logic [7:0] pairs,
                       input int first, input int count);
    logic [1:0] e;
    for (int k = first; k < first + count; k++) begin
      e = pairs[7 - 2 * (k / Q) -: 2];
      chk({tag, " oe"}, {sclOe, sdaOe}, e);
      chk({tag, " busy"}, busy, 1);
      chk({tag, " done"}, done, 0);
      @(negedge fastClock);
    end
  endtask

  task automatic finishCheck(input string tag, input logic rx, input logic arb);
    chk({tag, " done"}, done, 1);
    chk({tag, " busy"}, busy, 0);
    chk({tag, " ready"}, cmdReady, 1);
    chk({tag, " arbLost"}, arbLost, arb);
    chk({tag, " rxBit"}, rxBit, rx);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    reset    = 1'b1;
    cmdValid = 1'b0;
    cmd      = 2'b00;
    txBit    = 1'b0;
    sclOvr   = 1'b0;
    sclVal   = 1'b1;
    sdaOvr   = 1'b0;
    sdaVal   = 1'b1;
    repeat (3) @(negedge fastClock);

    chk("rst sclOe", sclOe, 0);
    chk("rst sdaOe", sdaOe, 0);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst rxBit", rxBit, 0);
    chk("rst arbLost", arbLost, 0);
    chk("rst ready", cmdReady, 1);
    reset = 1'b0;
    @(negedge fastClock);
    chk("idle ready", cmdReady, 1);

    // START: 00 x8, 01 x4, 11 x4, then hold 11
    issue(2'b00, 1'b0);
    watch("start", 8'b00_00_01_11, 0, 16);
    finishCheck("start end", 1'b0, 1'b0);
    @(negedge fastClock);
    chk("start pulse", done, 0);
    chk("start hold", {sclOe, sdaOe}, 2'b11);

    // WRITE 0 then WRITE 1 accepted in the done cycle
    issue(2'b10, 1'b0);
    watch("wr0", 8'b11_01_01_11, 0, 16);
    finishCheck("wr0 end", 1'b0, 1'b0);
    issue(2'b10, 1'b1);
    watch("wr1", 8'b10_00_00_10, 0, 16);
    finishCheck("wr1 end", 1'b1, 1'b0);
    @(negedge fastClock);

    // READ with SDA held low; a STOP request while busy must be ignored
    sdaOvr   = 1'b1;
    sdaVal   = 1'b0;
    cmdValid = 1'b1;
    cmd      = 2'b11;
    @(negedge fastClock);
    cmd   = 2'b01;
    txBit = 1'b1;
    watch("rd0", 8'b10_00_00_10, 0, 8);
    cmdValid = 1'b0;
    watch("rd0", 8'b10_00_00_10, 8, 8);
    finishCheck("rd0 end", 1'b0, 1'b0);
    @(negedge fastClock);

    // READ with SDA high
    sdaVal = 1'b1;
    issue(2'b11, 1'b0);
    watch("rd1", 8'b10_00_00_10, 0, 16);
    finishCheck("rd1 end", 1'b1, 1'b0);
    @(negedge fastClock);

    // READ with a 10-cycle stretch at the start of phase B
    sdaVal = 1'b0;
    issue(2'b11, 1'b0);
    watch("st", 8'b10_00_00_10, 0, 4);
    sclOvr = 1'b1;
    sclVal = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("st hold oe", {sclOe, sdaOe}, 2'b00);
      chk("st hold busy", busy, 1);
      chk("st hold rxBit", rxBit, 1);
      @(negedge fastClock);
    end
    sclOvr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("st high oe", {sclOe, sdaOe}, 2'b00);
      chk("st high rxBit", rxBit, 1);
      chk("st high busy", busy, 1);
      @(negedge fastClock);
    end
    chk("st sampled", rxBit, 0);
    watch("st cd", 8'b10_00_00_10, 8, 8);
    finishCheck("st end", 1'b0, 1'b0);
    @(negedge fastClock);

    // Arbitration loss: WRITE 1 while SDA held low
    issue(2'b10, 1'b1);
    watch("arb", 8'b10_00_00_10, 0, 16);
    finishCheck("arb end", 1'b0, 1'b1);
    @(negedge fastClock);
    chk("arb pulse", arbLost, 0);
    chk("arb done pulse", done, 0);
    sdaOvr = 1'b0;
    issue(2'b00, 1'b0);
    watch("start2", 8'b00_00_01_11, 0, 16);
    finishCheck("start2 end", 1'b0, 1'b0);
    @(negedge fastClock);

    // STOP aborted by asynchronous reset in phase C
    issue(2'b01, 1'b0);
    watch("stop", 8'b11_01_01_00, 0, 8);
    chk("stop C oe", {sclOe, sdaOe}, 2'b01);
    #2 reset = 1'b1;
    #1;
    chk("async sclOe", sclOe, 0);
    chk("async sdaOe", sdaOe, 0);
    chk("async busy", busy, 0);
    chk("async ready", cmdReady, 1);
    repeat (2) begin
      @(negedge fastClock);
      chk("rst no done", done, 0);
    end
    reset = 1'b0;
    @(negedge fastClock);
    chk("post rst ready", cmdReady, 1);
    chk("post rst done", done, 0);
    chk("post rst oe", {sclOe, sdaOe}, 2'b00);
    chk("post rst busy", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
